spart_rx: RTL and testbench
===========================

Name: spart_rx

Overview:
- UART receive deserializer; the downstream partner of the SPART transmit shifter on the serial line.
- Samples RxD using the same 16x oversampling enable strobe that drives the transmitter. Frame: 1 start, DATA_BITS data (LSB first), 1 stop.
- Presents the received byte with a ready-data-available (rda) flag, plus framing and overrun status, to the SPART bus interface.

Parameters:
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, en strobes per bit period; must be even and ≥4
SYNC_STAGES, 2, flops in RxD metastability synchronizer (≥2)

Ports:
clk  input  1  system clock
rst  input  1  reset
en  input  1  oversample strobe, one clk wide, OVERSAMPLE per bit time
RxD  input  1  asynchronous serial input, idle high
clr_rda  input  1  consumer has read data; clears rda/overrun
data  output  DATA_BITS  last completed received byte
rda  output  1  received data available
framing_err  output  1  stop bit of last completed frame sampled low
overrun  output  1  a frame completed while rda was still set
busy  output  1  high in START/DATA/STOP/BREAK

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All state is updated on posedge clk.
- Reset values: data=0, rda=0, framing_err=0, overrun=0, busy=0, FSM=IDLE, synchronizer flops=1, shift register=0, counters=0.
- RxD passes through SYNC_STAGES flops to form rxd_s. All decisions use rxd_s only.
- Sample counter scnt, width clog2(OVERSAMPLE), and bit counter bcnt change only on cycles with en=1. With en=0, every counter and the FSM hold.
- States:
  - IDLE: on en & rxd_s==0, load scnt=OVERSAMPLE/2-1 and go to START.
  - START: on en, if scnt≠0 decrement. If scnt==0:
    - rxd_s==0: load scnt=OVERSAMPLE-1, bcnt=0, go to DATA.
    - rxd_s==1: false start (glitch), return to IDLE. No flags change.
  - DATA: on en, if scnt≠0 decrement. If scnt==0: shift rxd_s into the MSB of the shift register (shift right, so the first bit ends in the LSB), reload scnt=OVERSAMPLE-1, increment bcnt. When bcnt reaches DATA_BITS-1 on that tick, go to STOP.
  - STOP: on en with scnt==0:
    - data←shift register; rda←1; framing_err←~rxd_s; overrun←rda (previous value).
    - rxd_s==1: go to IDLE. rxd_s==0: go to BREAK.
  - BREAK: wait for rxd_s==1 on an en tick, then go to IDLE. No new start is detected while in BREAK.
- Sampling is mid-bit: each sample falls OVERSAMPLE/2 strobes after the start edge is detected, plus an integer number of bit periods.
- Completion timing: rda rises on the clk edge of the stop-bit sample tick, ≈(DATA_BITS+1.5) bit times after the falling start edge, plus SYNC_STAGES clk.
- clr_rda clears rda and overrun on the next edge. If frame completion and clr_rda occur in the same cycle, completion wins: rda=1 and overrun=0. framing_err is not cleared by clr_rda; it is overwritten at each frame completion.
- On overrun, data is overwritten with the new byte. Only the newest byte is kept.
- busy=1 in every state except IDLE.
- Asynchronous reset mid-frame aborts the frame. No partial data reaches the data output, and all flags return to reset values.
- Back-to-back frames: IDLE can detect a new start on the en tick immediately after STOP completes. Zero idle strobes between frames are supported.

Test Plan:
- 0xA5 sent at 16 en/bit, stop high → data=0xA5, rda=1, framing_err=0, overrun=0. rda rises 152±1 en ticks after the start edge (+2 clk).
- Frame 0x3C with stop bit driven low, line released 2 bits later → data=0x3C, rda=1, framing_err=1. FSM passes through BREAK and no spurious frame follows.
- RxD low for 4 en ticks then high → returns to IDLE; rda, data and busy end at 0 and unchanged.
- Two frames 0x11 then 0x22 with no clr_rda → data=0x22, rda=1, overrun=1. Pulsing clr_rda then gives rda=0, overrun=0.
- clr_rda asserted in the completion cycle of frame 0x7E → rda=1 next cycle, data=0x7E.
- rst pulsed during bit 4 of 0xFF, then 0x81 sent → after rst all outputs are 0. The 0x81 frame is received cleanly with framing_err=0.

Source files
------------

// File: rtl/spart_rx.sv
// spart_rx: UART receive deserializer for the SPART block.
// Line is sampled on the shared 16x oversample strobe (en). The frame is one
// start bit, DATA_BITS data bits (LSB first) and one stop bit. Each sample is
// taken mid-bit: half a bit period after the start edge is seen, plus whole
// bit periods after that.
module spart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 RxD,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [SW-1:0]          scnt, scnt_n;
  logic [BW-1:0]          bcnt, bcnt_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   done;

  // RxD metastability synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // FSM, counters and shift register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      scnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
    end
  end

  // Next-state logic; nothing moves on cycles without an oversample strobe
  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    done    = 1'b0;
    if (en) begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            scnt_n  = HALF_M1;
            state_n = S_START;
          end
        end
        S_START: begin
          if (scnt != '0) begin
            scnt_n = scnt - 1'b1;
          end else if (!rxd_s) begin
            scnt_n  = FULL_M1;
            bcnt_n  = '0;
            state_n = S_DATA;
          end else begin
            // start bit gone by mid-bit: treat as a glitch
            state_n = S_IDLE;
          end
        end
        S_DATA: begin
          if (scnt != '0) begin
            scnt_n = scnt - 1'b1;
          end else begin
            shreg_n = {rxd_s, shreg} >> 1;
            scnt_n  = FULL_M1;
            bcnt_n  = bcnt + 1'b1;
            if (bcnt == LAST_BIT) state_n = S_STOP;
          end
        end
        S_STOP: begin
          if (scnt != '0) begin
            scnt_n = scnt - 1'b1;
          end else begin
            done    = 1'b1;
            state_n = rxd_s ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          // hold off start detection until the line returns high
          if (rxd_s) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Output byte and status flags; frame completion takes priority over clr_rda
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data        <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (done) begin
      data        <= shreg;
      rda         <= 1'b1;
      framing_err <= ~rxd_s;
      overrun     <= rda & ~clr_rda;
    end else if (clr_rda) begin
      rda     <= 1'b0;
      overrun <= 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: drives whole serial frames bit-by-bit on the oversample strobe
// and compares the receiver's outputs against a frame-level model of the
// received byte and status flags.
module tb_spart_rx;

  localparam int DB     = 8;
  localparam int OS     = 16;
  localparam int SS     = 2;
  localparam int EN_DIV = 4;
  // strobe (counted from the one after the start edge) on which the stop bit
  // is sampled: half a bit to mid-start, then DB data bits and the stop bit
  localparam int COMP   = 1 + OS/2 + DB*OS + OS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          RxD = 1'b1;
  logic          clr_rda = 1'b0;
  logic [DB-1:0] data;
  logic          rda, framing_err, overrun, busy;

  spart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .en(en), .RxD(RxD), .clr_rda(clr_rda),
    .data(data), .rda(rda), .framing_err(framing_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // frame-level reference state
  logic [DB-1:0] m_data = '0;
  bit            m_rda = 0, m_fe = 0, m_ovr = 0;
  int            n_chk = 0, n_err = 0;
  int            tick_cnt = 0, rise_tick = -1;
  bit            prev_rda = 0, brk_busy = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one oversample strobe, optionally with clr_rda in the same cycle
  task automatic tick(input bit clr);
    repeat (EN_DIV-1) @(posedge clk);
    #1 en = 1'b1; clr_rda = clr;
    @(posedge clk);
    #1 en = 1'b0; clr_rda = 1'b0;
    tick_cnt++;
    if (rda && !prev_rda && rise_tick < 0) rise_tick = tick_cnt;
    prev_rda = rda;
  endtask

  task automatic clr_pulse();
    tick(1'b1);
    m_rda = 0;
    m_ovr = 0;
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input bit stop,
                            input int extra_low, input bit clr_at_comp);
    tick_cnt  = 0;
    rise_tick = -1;
    RxD = 1'b0;
    repeat (OS) tick(1'b0);
    for (int i = 0; i < DB; i++) begin
      RxD = b[i];
      repeat (OS) tick(1'b0);
    end
    RxD = stop;
    for (int k = 0; k < OS + extra_low; k++)
      tick(clr_at_comp && (tick_cnt + 1 == COMP));
    if (!stop) begin
      brk_busy = busy;
      RxD = 1'b1;
      repeat (2) tick(1'b0);
    end
    m_ovr  = m_rda && !clr_at_comp;
    m_rda  = 1;
    m_data = b;
    m_fe   = !stop;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data"}, data, m_data);
    chk({tag, "_rda"}, rda, m_rda);
    chk({tag, "_ferr"}, framing_err, m_fe);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic chk_rise(input string tag);
    chk(tag, (rise_tick >= COMP-1 && rise_tick <= COMP+1), 1'b1);
  endtask

  initial begin
    logic [DB-1:0] b;
    bit            stop, clrc, was_rda;
    int            extra;

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    repeat (4) tick(1'b0);

    // short low pulse on the line is rejected at mid-start
    RxD = 1'b0;
    repeat (4) tick(1'b0);
    chk("glitch_busy_mid", busy, 1'b1);
    RxD = 1'b1;
    repeat (30) tick(1'b0);
    check_all("glitch");

    // clean frame, latency from start edge to rda
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    check_all("a5");
    chk_rise("a5_rise");
    clr_pulse();
    check_all("a5_clr");

    // stop bit low, line held low two more bits, then released
    send_frame(8'h3C, 1'b0, 2*OS, 1'b0);
    chk("brk_busy", brk_busy, 1'b1);
    check_all("brk");
    repeat (200) tick(1'b0);
    check_all("brk_quiet");

    // back-to-back frames without a read
    clr_pulse();
    send_frame(8'h11, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b0);
    check_all("ovr");
    clr_pulse();
    check_all("ovr_clr");

    // clr_rda coinciding with the completing strobe, rda already set
    send_frame(8'h55, 1'b1, 0, 1'b0);
    send_frame(8'h7E, 1'b1, 0, 1'b1);
    check_all("clr_comp");

    // asynchronous reset during bit 4 of 0xFF
    RxD = 1'b0;
    repeat (OS) tick(1'b0);
    RxD = 1'b1;
    repeat (4*OS + OS/2) tick(1'b0);
    #2 rst = 1'b1;
    #3;
    m_data = '0; m_rda = 0; m_fe = 0; m_ovr = 0; prev_rda = 0;
    check_all("rst_mid");
    rst = 1'b0;
    repeat (20) tick(1'b0);
    check_all("post_rst");
    send_frame(8'h81, 1'b1, 0, 1'b0);
    check_all("x81");
    chk_rise("x81_rise");

    // random frames, gaps, stop levels and reads
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(2) == 0) clr_pulse();
      repeat ($urandom_range(11)) tick(1'b0);
      b       = DB'($urandom);
      stop    = ($urandom_range(4) != 0);
      extra   = $urandom_range(39);
      clrc    = ($urandom_range(3) == 0);
      was_rda = m_rda;
      send_frame(b, stop, extra, clrc);
      check_all($sformatf("rnd%0d", n));
      if (!was_rda) chk_rise($sformatf("rnd%0d_rise", n));
      if (!stop) chk($sformatf("rnd%0d_brk", n), brk_busy, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
